// File: rtl/switch_led_ctrl.sv
// Multi-channel panel switch to LED controller.
// Each raw switch passes through a two-flop synchroniser and a per-channel
// debouncer. A global mode then picks the LED source: the debounced level,
// a toggle latch flipped on every debounced press, a blinking copy of the
// level, or all-off. Every LED output is registered.
module switch_led_ctrl #(
    parameter int N_CH            = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_DIV       = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] switch,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] sw_db,
    output logic [N_CH-1:0] sw_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;

    logic [N_CH-1:0]  sw_p0;
    logic [N_CH-1:0]  sw_p1;
    logic [CNT_W-1:0] db_cnt [N_CH];
    logic [N_CH-1:0]  tog;
    logic [BLK_W-1:0] blk_cnt;
    logic             phase;

    // LED source for the selected mode; blank is the fall-through case.
    function automatic logic [N_CH-1:0] led_sel(
        input logic [1:0]      m,
        input logic [N_CH-1:0] db,
        input logic [N_CH-1:0] tg,
        input logic            ph
    );
        logic [N_CH-1:0] r;
        r = '0;
        case (m)
            MODE_DIRECT: r = db;
            MODE_TOGGLE: r = tg;
            MODE_BLINK:  r = db & {N_CH{ph}};
            default:     r = '0;
        endcase
        return r;
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= switch;
            sw_p1 <= sw_p0;
        end
    end

    // Debounce: a differing level must persist DEBOUNCE_CYCLES clocks before it
    // is accepted; any return to the accepted level restarts the count. The
    // rise pulse is registered on the same edge that accepts a new high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
            sw_db   <= '0;
            sw_rise <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sw_rise[i] <= 1'b0;
                if (sw_p1[i] == sw_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != CNT_LAST) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db_cnt[i]  <= '0;
                    sw_db[i]   <= sw_p1[i];
                    sw_rise[i] <= sw_p1[i];
                end
            end
        end
    end

    // Toggle latches flip on every debounced press, whatever the mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog <= '0;
        end else begin
            tog <= tog ^ sw_rise;
        end
    end

    // Free-running blink prescaler; the phase inverts on each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (blk_cnt == BLK_LAST) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // Stage out: registered LED drive from the mode selected this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_sel(mode, sw_db, tog, phase);
        end
    end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl with N_CH=3, DEBOUNCE_CYCLES=4, BLINK_DIV=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// that follows each rising edge.
module tb_switch_led_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] switch;
    logic [1:0] mode;
    logic [2:0] led;
    logic [2:0] sw_db;
    logic [2:0] sw_rise;

    int tests;
    int fails;

    switch_led_ctrl #(
        .N_CH(3),
        .DEBOUNCE_CYCLES(4),
        .BLINK_DIV(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch(switch),
        .mode(mode),
        .led(led),
        .sw_db(sw_db),
        .sw_rise(sw_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] sw;
        logic [1:0] mode;
        logic [2:0] e_led;
        logic [2:0] e_db;
        logic [2:0] e_rise;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected blink-mode LED k edges after reset release with a held level.
    function automatic logic [2:0] blink_exp(input int k, input logic [2:0] lvl);
        if ((k - 1) >= 6 && (((k - 1) / 3) % 2) == 1) return lvl;
        return 3'b000;
    endfunction

    initial begin
        int rise_cnt;
        int rise_at;
        int rise_other;
        int led_on;
        logic [2:0] e;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        switch = 3'b111;
        mode = 2'b00;

        // Reset, direct-mode latency, then a sweep through the other modes.
        vecs[0]  = '{1'b1, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{1'b1, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[2]  = '{1'b0, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[3]  = '{1'b0, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[4]  = '{1'b0, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[5]  = '{1'b0, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[6]  = '{1'b0, 3'b111, 2'b00, 3'b000, 3'b000, 3'b000};
        vecs[7]  = '{1'b0, 3'b111, 2'b00, 3'b000, 3'b111, 3'b111};
        vecs[8]  = '{1'b0, 3'b111, 2'b00, 3'b111, 3'b111, 3'b000};
        vecs[9]  = '{1'b0, 3'b111, 2'b11, 3'b000, 3'b111, 3'b000};
        vecs[10] = '{1'b0, 3'b111, 2'b01, 3'b111, 3'b111, 3'b000};
        vecs[11] = '{1'b0, 3'b111, 2'b10, 3'b111, 3'b111, 3'b000};
        vecs[12] = '{1'b0, 3'b111, 2'b10, 3'b111, 3'b111, 3'b000};
        vecs[13] = '{1'b0, 3'b111, 2'b10, 3'b111, 3'b111, 3'b000};
        vecs[14] = '{1'b0, 3'b111, 2'b10, 3'b000, 3'b111, 3'b000};
        vecs[15] = '{1'b0, 3'b000, 2'b00, 3'b111, 3'b111, 3'b000};

        for (int i = 0; i < NVEC; i++) begin
            rst    = vecs[i].rst;
            switch = vecs[i].sw;
            mode   = vecs[i].mode;
            tick();
            check($sformatf("vec%0d_led", i), led, vecs[i].e_led);
            check($sformatf("vec%0d_sw_db", i), sw_db, vecs[i].e_db);
            check($sformatf("vec%0d_sw_rise", i), sw_rise, vecs[i].e_rise);
        end

        // Glitch rejection: 3 high, 1 low, then 10 high on channel 0.
        switch = 3'b000;
        mode = 2'b00;
        do_reset();
        rise_cnt = 0;
        rise_at = 0;
        for (int k = 1; k <= 14; k++) begin
            switch = (k <= 3 || k >= 5) ? 3'b001 : 3'b000;
            tick();
            if (sw_rise[0]) begin
                rise_cnt++;
                rise_at = k;
            end
        end
        check("glitch_rise_count", rise_cnt, 1);
        check("glitch_rise_edge", rise_at, 10);
        check("glitch_final_db", sw_db, 3'b001);

        // Toggle mode: three clean presses on channel 1.
        switch = 3'b000;
        mode = 2'b01;
        do_reset();
        rise_cnt = 0;
        rise_other = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                switch = (c < 8) ? 3'b010 : 3'b000;
                tick();
                rise_cnt += int'(sw_rise[1]);
                rise_other += int'(sw_rise[0]) + int'(sw_rise[2]);
            end
            check($sformatf("toggle_led1_press%0d", p), led[1], (p % 2 == 0) ? 1 : 0);
        end
        check("toggle_rise_cycles", rise_cnt, 3);
        check("toggle_rise_other", rise_other, 0);

        // Blank retains the latch: tog=010 now; press ch1 while blanked.
        mode = 2'b11;
        tick();
        check("blank_led", led, 3'b000);
        led_on = 0;
        for (int c = 0; c < 16; c++) begin
            switch = (c < 8) ? 3'b010 : 3'b000;
            tick();
            if (led != 3'b000) led_on++;
        end
        check("blank_led_stays_off", led_on, 0);
        mode = 2'b01;
        tick();
        check("retain_toggled_latch", led, 3'b000);

        // Blink mode with 101 held.
        switch = 3'b101;
        mode = 2'b10;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            tick();
            e = blink_exp(k, 3'b101);
            check($sformatf("blink_edge%0d", k), led, e);
        end

        // Reset mid-debounce and mid-blink.
        switch = 3'b111;
        mode = 2'b00;
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        check("mid_pre_led", led, 3'b111);
        switch = 3'b000;
        for (int k = 0; k < 4; k++) tick();
        check("mid_debounce_led", led, 3'b111);
        check("mid_debounce_db", sw_db, 3'b111);
        switch = 3'b111;
        mode = 2'b10;
        rst = 1'b1;
        tick();
        check("mid_rst_led", led, 3'b000);
        check("mid_rst_db", sw_db, 3'b000);
        check("mid_rst_rise", sw_rise, 3'b000);
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 5) check("restart_db_not_yet", sw_db, 3'b000);
            if (k == 6) check("restart_db_accept", sw_db, 3'b111);
            e = blink_exp(k, 3'b111);
            check($sformatf("restart_blink_edge%0d", k), led, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
